// File: rtl/mtimer.sv
// Machine timer: 64-bit prescaled mtime counter, 64-bit mtimecmp and a level
// timer interrupt. It is a bus peripheral with a small word-addressed register map.
module mtimer #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        write_en,
  input  logic [4:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        intr_timer
);

  localparam int unsigned WORD_W = 3;
  localparam logic [WORD_W-1:0] A_MTIME_LO    = 3'd0;
  localparam logic [WORD_W-1:0] A_MTIME_HI    = 3'd1;
  localparam logic [WORD_W-1:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [WORD_W-1:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [WORD_W-1:0] A_CTRL        = 3'd4;
  localparam logic [WORD_W-1:0] A_STATUS      = 3'd5;

  logic [31:0]           mtime_lo, mtime_hi;
  logic [31:0]           cmp_lo, cmp_hi;
  logic [31:0]           shadow_hi;
  logic                  en;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] pcnt;

  logic [WORD_W-1:0] word;
  logic              wr, rd;
  logic              wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, rd_lo;
  logic              tick;
  logic [63:0]       mtime_inc;
  logic              unused_addr;

  // Address decode and access qualification
  assign word        = addr[4:2];
  assign unused_addr = ^addr[1:0];
  assign wr          = sel && write_en;
  assign rd          = sel && !write_en;
  assign wr_lo       = wr && (word == A_MTIME_LO);
  assign wr_hi       = wr && (word == A_MTIME_HI);
  assign wr_cmp_lo   = wr && (word == A_MTIMECMP_LO);
  assign wr_cmp_hi   = wr && (word == A_MTIMECMP_HI);
  assign wr_ctrl     = wr && (word == A_CTRL);
  assign rd_lo       = rd && (word == A_MTIME_LO);

  // A CTRL write restarts the prescaler phase and swallows this cycle's tick
  assign tick      = en && (pcnt == div) && !wr_ctrl;
  assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;

  // Control register and prescaler counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      en   <= 1'b0;
      div  <= '0;
      pcnt <= '0;
    end else if (wr_ctrl) begin
      en   <= data_in[0];
      div  <= data_in[8 +: PRESCALE_W];
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
    end
  end

  // mtime: bus writes win per half; a HI write still lets lo advance on a tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_lo <= '0;
      mtime_hi <= '0;
    end else if (wr_lo) begin
      mtime_lo <= data_in;
    end else if (wr_hi) begin
      mtime_hi <= data_in;
      if (tick) mtime_lo <= mtime_inc[31:0];
    end else if (tick) begin
      mtime_lo <= mtime_inc[31:0];
      mtime_hi <= mtime_inc[63:32];
    end
  end

  // Snapshot of hi taken with each lo read so a lo/hi pair is coherent
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_hi <= '0;
    end else if (rd_lo) begin
      shadow_hi <= mtime_hi;
    end else if (wr_hi) begin
      shadow_hi <= data_in;
    end
  end

  // Compare register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmp_lo <= '1;
      cmp_hi <= '1;
    end else begin
      if (wr_cmp_lo) cmp_lo <= data_in;
      if (wr_cmp_hi) cmp_hi <= data_in;
    end
  end

  // Interrupt level follows the compare one cycle late, independent of EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      intr_timer <= 1'b0;
    end else begin
      intr_timer <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
    end
  end

  // Read mux; zero whenever the block is not selected
  always_comb begin
    data_out = '0;
    if (sel) begin
      case (word)
        A_MTIME_LO:    data_out = mtime_lo;
        A_MTIME_HI:    data_out = shadow_hi;
        A_MTIMECMP_LO: data_out = cmp_lo;
        A_MTIMECMP_HI: data_out = cmp_hi;
        A_CTRL:        data_out = 32'({div, 7'b0, en});
        A_STATUS:      data_out = 32'(intr_timer);
        default:       data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register-map tables plus timing sequences for
// prescaler, interrupt, coherent 64-bit read, write/tick collision, wrap, reset.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        write_en;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        intr_timer;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t rst_tbl[8];
  vec_t rw_tbl[18];

  mtimer #(.PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .write_en   (write_en),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .intr_timer (intr_timer)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every bus task starts and ends at a negedge and spans exactly one posedge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; write_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    sel = 1'b1; write_en = 1'b0; addr = a;
    #1;
    check(name, data_out, exp);
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string name);
    if (v.we) wr(v.addr, v.data);
    else      rd(v.addr, v.exp, name);
  endtask

  initial begin
    bit found;
    bit idle_ok;

    // Reset-state reads
    rst_tbl[0] = '{1'b0, 5'h00, 32'h0, 32'h0000_0000};
    rst_tbl[1] = '{1'b0, 5'h04, 32'h0, 32'h0000_0000};
    rst_tbl[2] = '{1'b0, 5'h08, 32'h0, 32'hFFFF_FFFF};
    rst_tbl[3] = '{1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF};
    rst_tbl[4] = '{1'b0, 5'h10, 32'h0, 32'h0000_0000};
    rst_tbl[5] = '{1'b0, 5'h14, 32'h0, 32'h0000_0000};
    rst_tbl[6] = '{1'b0, 5'h18, 32'h0, 32'h0000_0000};
    rst_tbl[7] = '{1'b0, 5'h1C, 32'h0, 32'h0000_0000};

    // Register read/write with the timer disabled
    rw_tbl[0]  = '{1'b1, 5'h10, 32'hFFFF_FF00, 32'h0};
    rw_tbl[1]  = '{1'b0, 5'h10, 32'h0,         32'h0000_FF00};
    rw_tbl[2]  = '{1'b1, 5'h10, 32'h0000_0000, 32'h0};
    rw_tbl[3]  = '{1'b0, 5'h11, 32'h0,         32'h0000_0000};
    rw_tbl[4]  = '{1'b1, 5'h14, 32'h0000_0001, 32'h0};
    rw_tbl[5]  = '{1'b0, 5'h14, 32'h0,         32'h0000_0000};
    rw_tbl[6]  = '{1'b1, 5'h18, 32'hDEAD_BEEF, 32'h0};
    rw_tbl[7]  = '{1'b0, 5'h18, 32'h0,         32'h0000_0000};
    rw_tbl[8]  = '{1'b1, 5'h08, 32'h1234_5678, 32'h0};
    rw_tbl[9]  = '{1'b0, 5'h0A, 32'h0,         32'h1234_5678};
    rw_tbl[10] = '{1'b1, 5'h08, 32'hFFFF_FFFF, 32'h0};
    rw_tbl[11] = '{1'b1, 5'h00, 32'hA5A5_0001, 32'h0};
    rw_tbl[12] = '{1'b1, 5'h04, 32'h0000_0042, 32'h0};
    rw_tbl[13] = '{1'b0, 5'h04, 32'h0,         32'h0000_0042};
    rw_tbl[14] = '{1'b0, 5'h00, 32'h0,         32'hA5A5_0001};
    rw_tbl[15] = '{1'b1, 5'h00, 32'h0000_0000, 32'h0};
    rw_tbl[16] = '{1'b1, 5'h04, 32'h0000_0000, 32'h0};
    rw_tbl[17] = '{1'b0, 5'h00, 32'h0,         32'h0000_0000};

    reset = 1'b0; sel = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    check("intr_after_reset", 32'(intr_timer), 32'h0);
    for (int i = 0; i < 8; i++) apply(rst_tbl[i], $sformatf("rst_tbl[%0d]", i));

    // Not selected: read data must be zero even at a nonzero register
    addr = 5'h08; write_en = 1'b0; sel = 1'b0;
    #1;
    check("sel_low_zero", data_out, 32'h0);
    @(negedge clk);

    // Disabled timer: no interrupt and no counting for 100 cycles
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (intr_timer !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_intr_low", 32'(idle_ok), 32'h1);
    rd(5'h00, 32'h0, "idle_mtime_lo");

    for (int i = 0; i < 18; i++) apply(rw_tbl[i], $sformatf("rw_tbl[%0d]", i));

    // Prescaler DIV=3: first tick 4 cycles after the write, 10 ticks in 40
    wr(5'h10, 32'h0000_0301);
    repeat (39) @(negedge clk);
    rd(5'h00, 32'd9, "div3_39cyc");
    rd(5'h00, 32'd10, "div3_40cyc");

    // Interrupt rises one cycle after mtime reaches mtimecmp
    wr(5'h10, 32'h0000_0001);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'd20);
    sel = 1'b1; write_en = 1'b0; addr = 5'h00;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (data_out == 32'd20) begin
        found = 1'b1;
        check("intr_at_eq", 32'(intr_timer), 32'h0);
        @(negedge clk);
        #1;
        check("intr_rise", 32'(intr_timer), 32'h1);
        check("lo_after_eq", data_out, 32'd21);
      end else begin
        @(negedge clk);
      end
    end
    check("reach_cmp_in_time", 32'(found), 32'h1);
    @(negedge clk);
    sel = 1'b0;
    rd(5'h14, 32'h1, "status_set");
    wr(5'h08, 32'd1000);
    check("intr_hold_at_write", 32'(intr_timer), 32'h1);
    @(negedge clk);
    check("intr_drop", 32'(intr_timer), 32'h0);

    // Coherent 64-bit read across a lo carry (DIV=0)
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    @(negedge clk);
    rd(5'h00, 32'hFFFF_FFFF, "snap_lo");
    rd(5'h04, 32'h0, "snap_hi_old");
    rd(5'h00, 32'h1, "snap2_lo");
    rd(5'h04, 32'h1, "snap2_hi");

    // LO write on a tick with lo = all ones: no carry into hi
    wr(5'h04, 32'h5);
    wr(5'h00, 32'hFFFF_FFFE);
    @(negedge clk);
    wr(5'h00, 32'h55);
    rd(5'h00, 32'h55, "lo_write_tick");
    rd(5'h04, 32'h5, "hi_no_carry");

    // HI write on a tick: lo still advances
    wr(5'h04, 32'h7);
    rd(5'h00, 32'h58, "hi_write_lo_inc");
    rd(5'h04, 32'h7, "hi_write_val");
    wr(5'h04, 32'h9);
    rd(5'h04, 32'h9, "hi_write_shadow");

    // 64-bit wrap
    wr(5'h10, 32'h0);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'h1);
    rd(5'h00, 32'hFFFF_FFFF, "wrap_pre_lo");
    rd(5'h04, 32'hFFFF_FFFF, "wrap_pre_hi");
    rd(5'h00, 32'h1, "wrap_post_lo");
    rd(5'h04, 32'h0, "wrap_post_hi");

    // Reset mid-count with interrupt asserted; a concurrent write is ignored
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'h0);
    wr(5'h10, 32'h0000_0501);
    repeat (2) @(negedge clk);
    check("intr_before_reset", 32'(intr_timer), 32'h1);
    reset = 1'b0; sel = 1'b1; write_en = 1'b1; addr = 5'h08; data_in = 32'h5;
    @(negedge clk);
    reset = 1'b1; sel = 1'b0; write_en = 1'b0;
    check("intr_after_reset2", 32'(intr_timer), 32'h0);
    for (int i = 0; i < 8; i++) apply(rst_tbl[i], $sformatf("rst2_tbl[%0d]", i));
    check("intr_stays_low", 32'(intr_timer), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
Memory-mapped machine timer that generates the `intr_timer` level consumed by the CSR block's `mip[7]` path.
- Holds a 64-bit free-running `mtime` counter behind a programmable prescaler, plus a 64-bit `mtimecmp` compare register.
- Drives `intr_timer` high while `mtime >= mtimecmp`.
- Sits on the core's data bus as a peripheral. Firmware clears the interrupt by writing `mtimecmp`, not through the CSR block.

Parameters:
- `PRESCALE_W`, 8, width of the prescaler divisor field and the internal prescaler counter.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-low reset
- `sel`  input  1  bus select; an access occurs only when high
- `write_en`  input  1  1 = write, 0 = read (qualified by `sel`)
- `addr`  input  5  byte address; bits [1:0] ignored
- `data_in`  input  32  write data
- `data_out`  output  32  read data, combinational
- `intr_timer`  output  1  timer interrupt level, registered

Behaviour:
- Reset: when `reset` is 0 at a `clk` edge:
  - `mtime` = 0; `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `ctrl` = 0 (timer disabled, divisor 0).
  - Prescaler counter `pcnt` = 0; `shadow_hi` = 0; `intr_timer` = 0.
  - Reset dominates every other update in the same cycle.
- Register map (word offsets):
  - 0x00 `MTIME_LO` RW
  - 0x04 `MTIME_HI` RW (reads return `shadow_hi`)
  - 0x08 `MTIMECMP_LO` RW
  - 0x0C `MTIMECMP_HI` RW
  - 0x10 `CTRL` RW: bit0 `EN`; bits [8+PRESCALE_W-1:8] `DIV`; other bits read 0
  - 0x14 `STATUS` RO: bit0 = `intr_timer`
  - Unmapped reads return 0; unmapped writes and writes to `STATUS` are ignored.
- `data_out` is 0 when `sel` = 0.
- Prescaler:
  - Active only while `EN` = 1.
  - `tick` = `EN && (pcnt == DIV)`.
  - On `tick`, `pcnt` <= 0; otherwise `pcnt` <= `pcnt` + 1.
  - `DIV` = 0 gives a tick every cycle; `DIV` = N gives a tick every N+1 cycles.
  - While `EN` = 0, `pcnt` holds and `mtime` holds.
  - Any write to `CTRL` sets `pcnt` <= 0 and suppresses the tick in that cycle.
- Increment:
  - On `tick`, `mtime` <= `mtime` + 1, 64-bit, wrapping at 2^64-1 to 0.
- Write/increment collision in the same cycle:
  - Write to `MTIME_LO`: lo <= `data_in`, hi unchanged (no carry applied).
  - Write to `MTIME_HI`: hi <= `data_in`; lo <= lo + 1 if `tick` (its carry is discarded).
  - Writes to `mtimecmp` never interact with the tick.
- Atomic 64-bit read:
  - A read of `MTIME_LO` (`sel` && !`write_en` && addr 0x00) returns live lo and, at the clock edge, loads `shadow_hi` <= current hi (the pre-increment value, consistent with the returned lo).
  - A write to `MTIME_HI` also loads `shadow_hi` <= `data_in`.
  - A read of `MTIME_HI` returns `shadow_hi`.
- Interrupt:
  - `intr_timer` <= (`mtime` >= `mtimecmp`), unsigned 64-bit compare on current register values. Latency is one cycle from the compare condition becoming true.
  - Level, not sticky: writing `mtimecmp` above `mtime` drops `intr_timer` on the cycle after the write lands.
  - The compare is evaluated regardless of `EN`.
- Reset mid-count: the prescaler phase is lost; there is no residual pending interrupt after reset.

Test Plan:
- Reset, then read all registers → `MTIME` 0/0, `MTIMECMP` FFFFFFFF/FFFFFFFF, `CTRL` 0, `STATUS` 0, `intr_timer` = 0 for 100 cycles (`EN` = 0, `mtime` stays 0).
- Write `CTRL` = 0x0301 (`EN`, `DIV` = 3), run 40 cycles → `mtime` = 10 (one tick per 4 cycles, first tick 4 cycles after the write).
- `CTRL` = 1, `MTIMECMP_HI` = 0, `MTIMECMP_LO` = 20 → `intr_timer` rises exactly 1 cycle after `mtime` reaches 20; `STATUS` = 1. Write `MTIMECMP_LO` = 1000 → `intr_timer` = 0 on the next cycle.
- Write `MTIME_HI` = 0, `MTIME_LO` = 0xFFFFFFFE with `EN` = 1, `DIV` = 0. Read `MTIME_LO` on the cycle lo = 0xFFFFFFFF, then read `MTIME_HI` → returns 0 although live hi is now 1. The next lo read plus hi read returns hi = 1.
- Write `MTIME_LO` = 0x55 on a tick cycle with lo = 0xFFFFFFFF → lo = 0x55, hi unchanged. Separately, `mtime` = 64'hFFFF_FFFF_FFFF_FFFF with a tick → wraps to 0.
- Assert `reset` = 0 for one cycle while `intr_timer` = 1 and `pcnt` is mid-count → the next cycle shows all reset values and `intr_timer` = 0.
